// File: rtl/keysw_pkg.sv
// Shared constants for the KEY/SW memory-mapped responder:
// register addresses and CTRL bit positions.
package keysw_pkg;

    localparam logic [31:0] ADDR_KDATA = 32'hFFFFF080;
    localparam logic [31:0] ADDR_KCTRL = 32'hFFFFF084;
    localparam logic [31:0] ADDR_SDATA = 32'hFFFFF090;
    localparam logic [31:0] ADDR_SCTRL = 32'hFFFFF094;

    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_IE    = 4;

    localparam int DEV_KEY = 0;
    localparam int DEV_SW  = 1;
    localparam int NDEV    = 2;

    function automatic logic [31:0] ctrl_word(
        input logic rdy,
        input logic ovr,
        input logic ie
    );
        logic [31:0] w;
        w             = '0;
        w[CTRL_READY] = rdy;
        w[CTRL_OVR]   = ovr;
        w[CTRL_IE]    = ie;
        return w;
    endfunction

endpackage

// File: rtl/keysw_io_responder_if.sv
// M-stage data bus between the CPU (master) and an I/O
// responder (slave); rdata/sel are combinational from addr.
interface keysw_io_responder_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             rd_en;
    logic             wr_en;
    logic [DBITS-1:0] wdata;
    logic [DBITS-1:0] rdata;
    logic             sel;

    modport master (
        output addr, rd_en, wr_en, wdata,
        input  rdata, sel
    );

    modport slave (
        input  addr, rd_en, wr_en, wdata,
        output rdata, sel
    );
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser, stability counter and committed DATA
// register; commit_o is high in the cycle before DATA updates.
module io_debounce #(
    parameter int WIDTH  = 4,
    parameter int CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] data_o,
    output logic             commit_o
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // sync1 is next cycle's candidate: comparing it with sync2
    // restarts the count on the edge the candidate changes.
    always_comb begin
        cnt_d    = cnt_q;
        data_d   = data_q;
        commit_o = 1'b0;
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (sync2_q != data_q) begin
            if (cnt_q == CNT_LAST) begin
                data_d   = sync2_q;
                cnt_d    = '0;
                commit_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/keysw_io_responder.sv
// KEY/SW bus responder: decode, READY/OVERRUN/IE flags, read mux.
// Optional interrupt output enabled by KEYSW_IRQ_EN.
module keysw_io_responder
    import keysw_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int KEYBITS         = 4,
    parameter int SWBITS          = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0] ADDRKEY   = DBITS'(ADDR_KDATA),
    parameter logic [DBITS-1:0] ADDRKCTRL = DBITS'(ADDR_KCTRL),
    parameter logic [DBITS-1:0] ADDRSW    = DBITS'(ADDR_SDATA),
    parameter logic [DBITS-1:0] ADDRSCTRL = DBITS'(ADDR_SCTRL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    keysw_io_responder_if.slave bus,
    output logic               irq
);
    logic [KEYBITS-1:0] kdata;
    logic [SWBITS-1:0]  sdata;
    logic               kcommit, scommit;

    // Keys are active-low on the board; present pressed=1.
    io_debounce #(.WIDTH(KEYBITS), .CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk      (clk),
        .reset    (reset),
        .din_i    (~KEY),
        .data_o   (kdata),
        .commit_o (kcommit)
    );

    io_debounce #(.WIDTH(SWBITS), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk      (clk),
        .reset    (reset),
        .din_i    (SW),
        .data_o   (sdata),
        .commit_o (scommit)
    );

    logic kd_hit, kc_hit, sd_hit, sc_hit;
    logic [NDEV-1:0] commit, rd_hit, wr_hit;
    logic [NDEV-1:0] ready_q, ready_d;
    logic [NDEV-1:0] ovr_q, ovr_d;
    logic [NDEV-1:0] ie_q;

    assign kd_hit = (bus.addr == ADDRKEY);
    assign kc_hit = (bus.addr == ADDRKCTRL);
    assign sd_hit = (bus.addr == ADDRSW);
    assign sc_hit = (bus.addr == ADDRSCTRL);

    assign commit = {scommit, kcommit};
    // A simultaneous write masks the read side effect.
    assign rd_hit = {NDEV{bus.rd_en & ~bus.wr_en}} & {sd_hit, kd_hit};
    assign wr_hit = {NDEV{bus.wr_en}} & {sc_hit, kc_hit};

    always_comb begin
        ready_d = ready_q;
        ovr_d   = ovr_q;
        for (int i = 0; i < NDEV; i++) begin
            if (commit[i]) begin
                ready_d[i] = 1'b1;
            end else if (rd_hit[i]) begin
                ready_d[i] = 1'b0;
            end
            if (commit[i] && ready_q[i] && !rd_hit[i]) begin
                ovr_d[i] = 1'b1;
            end else if (wr_hit[i] && !bus.wdata[CTRL_OVR]) begin
                ovr_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= '0;
            ovr_q   <= '0;
        end else begin
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef KEYSW_IRQ_EN
    logic [NDEV-1:0] ie_d;
    logic            irq_q, irq_d;

    always_comb begin
        ie_d = ie_q;
        for (int i = 0; i < NDEV; i++) begin
            if (wr_hit[i]) begin
                ie_d[i] = bus.wdata[CTRL_IE];
            end
        end
    end

    assign irq_d = |(ready_q & ie_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign ie_q = '0;
    assign irq  = 1'b0;
`endif

    logic [DBITS-1:0] rdata_d;
    logic             unused_wdata;

    assign unused_wdata = ^bus.wdata;

    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            kd_hit:  rdata_d = DBITS'(kdata);
            sd_hit:  rdata_d = DBITS'(sdata);
            kc_hit:  rdata_d = DBITS'(ctrl_word(ready_q[DEV_KEY],
                                                ovr_q[DEV_KEY],
                                                ie_q[DEV_KEY]));
            sc_hit:  rdata_d = DBITS'(ctrl_word(ready_q[DEV_SW],
                                                ovr_q[DEV_SW],
                                                ie_q[DEV_SW]));
            default: rdata_d = '0;
        endcase
    end

    assign bus.rdata = rdata_d;
    assign bus.sel   = kd_hit | kc_hit | sd_hit | sc_hit;
endmodule

// File: tb/tb_keysw_io_responder.sv
// Directed bench for keysw_io_responder with DEBOUNCE_CYCLES=4.
// Checks irq behaviour both with and without KEYSW_IRQ_EN.
module tb_keysw_io_responder;
    import keysw_pkg::*;

    localparam logic [31:0] KD = ADDR_KDATA;
    localparam logic [31:0] KC = ADDR_KCTRL;
    localparam logic [31:0] SD = ADDR_SDATA;
    localparam logic [31:0] SC = ADDR_SCTRL;
`ifdef KEYSW_IRQ_EN
    localparam logic [31:0] IEB = 32'h10;
    localparam logic        IRQ_ON = 1'b1;
`else
    localparam logic [31:0] IEB = 32'h00;
    localparam logic        IRQ_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic       irq;
    int         tests;
    int         failed;

    keysw_io_responder_if #(.DBITS(32)) bus ();

    keysw_io_responder #(
        .DBITS(32), .KEYBITS(4), .SWBITS(10), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .KEY   (KEY),
        .SW    (SW),
        .bus   (bus),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        KEY = 4'b1111;
        SW = '0;
        repeat (3) tick();
        peek(KC, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL reset_kctrl: got %h want %h", v, 32'h0);
        end
        peek(SC, v);
        tests++;
        if (v !== 32'h0 || bus.sel !== 1'b1) begin
            failed++;
            $display("FAIL reset_sctrl: got %h sel %b want 0 sel 1", v, bus.sel);
        end
        tests++;
        if (irq !== 1'b0) begin
            failed++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
    endtask

    task automatic test_key_commit();
        logic [31:0] v;
        KEY = 4'b1110;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        peek(KD, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL key_early: got %h want %h", v, 32'h0);
        end
        tick();
        peek(KD, v);
        tests++;
        if (v !== 32'h1) begin
            failed++;
            $display("FAIL key_data: got %h want %h", v, 32'h1);
        end
        peek(KC, v);
        tests++;
        if (v !== 32'h1) begin
            failed++;
            $display("FAIL key_ready: got %h want %h", v, 32'h1);
        end
        bus_read(KD);
        peek(KC, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL key_read_clear: got %h want %h", v, 32'h0);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            SW = 10'h3FF;
            tick();
            tick();
            SW = 10'h000;
            tick();
            peek(SC, v);
            tests++;
            if (v !== 32'h0) begin
                failed++;
                $display("FAIL glitch_sctrl[%0d]: got %h want %h", i, v, 32'h0);
            end
            tick();
        end
        repeat (8) tick();
        peek(SD, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL glitch_sdata: got %h want %h", v, 32'h0);
        end
        peek(SC, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL glitch_ready: got %h want %h", v, 32'h0);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        SW = 10'h001;
        repeat (8) tick();
        peek(SC, v);
        tests++;
        if (v !== 32'h1) begin
            failed++;
            $display("FAIL ovr_first: got %h want %h", v, 32'h1);
        end
        SW = 10'h002;
        repeat (8) tick();
        peek(SD, v);
        tests++;
        if (v !== 32'h2) begin
            failed++;
            $display("FAIL ovr_sdata: got %h want %h", v, 32'h2);
        end
        peek(SC, v);
        tests++;
        if (v !== 32'h5) begin
            failed++;
            $display("FAIL ovr_sctrl: got %h want %h", v, 32'h5);
        end
        bus_write(SC, 32'h4);
        peek(SC, v);
        tests++;
        if (v !== 32'h5) begin
            failed++;
            $display("FAIL ovr_keep: got %h want %h", v, 32'h5);
        end
        bus_write(SD, 32'h3FF);
        bus_write(SC, 32'h0);
        peek(SC, v);
        tests++;
        if (v !== 32'h1) begin
            failed++;
            $display("FAIL ovr_clear: got %h want %h", v, 32'h1);
        end
        peek(SD, v);
        tests++;
        if (v !== 32'h2) begin
            failed++;
            $display("FAIL sdata_ro: got %h want %h", v, 32'h2);
        end
        bus_read(SD);
    endtask

    task automatic test_commit_read();
        logic [31:0] v;
        KEY = 4'b1100;
        repeat (8) tick();
        peek(KC, v);
        tests++;
        if (v !== 32'h1) begin
            failed++;
            $display("FAIL cr_setup: got %h want %h", v, 32'h1);
        end
        KEY = 4'b1110;
        repeat (5) tick();
        peek(KD, v);
        tests++;
        if (v !== 32'h3) begin
            failed++;
            $display("FAIL cr_before: got %h want %h", v, 32'h3);
        end
        bus_read(KD);
        peek(KC, v);
        tests++;
        if (v !== 32'h1) begin
            failed++;
            $display("FAIL cr_kctrl: got %h want %h", v, 32'h1);
        end
        peek(KD, v);
        tests++;
        if (v !== 32'h1) begin
            failed++;
            $display("FAIL cr_kdata: got %h want %h", v, 32'h1);
        end
        bus_read(KD);
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        KEY = 4'b1111;
        SW = 10'h000;
        repeat (4) tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            peek(KD, v);
            tests++;
            if (v !== 32'h0) begin
                failed++;
                $display("FAIL rst_kdata[%0d]: got %h want 0", i, v);
            end
            peek(KC, v);
            tests++;
            if (v !== 32'h0) begin
                failed++;
                $display("FAIL rst_kctrl[%0d]: got %h want 0", i, v);
            end
            peek(SD, v);
            tests++;
            if (v !== 32'h0) begin
                failed++;
                $display("FAIL rst_sdata[%0d]: got %h want 0", i, v);
            end
        end
        peek(32'h00000100, v);
        tests++;
        if (v !== 32'h0 || bus.sel !== 1'b0) begin
            failed++;
            $display("FAIL unmapped: got %h sel %b want 0 sel 0", v, bus.sel);
        end
        reset = 1'b0;
        repeat (10) tick();
        peek(KC, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL post_rst_kctrl: got %h want 0", v);
        end
        peek(SC, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL post_rst_sctrl: got %h want 0", v);
        end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        bus_write(KC, 32'h10);
        peek(KC, v);
        tests++;
        if (v !== IEB) begin
            failed++;
            $display("FAIL irq_ie: got %h want %h", v, IEB);
        end
        KEY = 4'b1110;
        repeat (6) tick();
        peek(KC, v);
        tests++;
        if (v !== (IEB | 32'h1) || irq !== 1'b0) begin
            failed++;
            $display("FAIL irq_lag: got %h irq %b want %h irq 0", v, irq, IEB | 32'h1);
        end
        tick();
        tests++;
        if (irq !== IRQ_ON) begin
            failed++;
            $display("FAIL irq_set: got %b want %b", irq, IRQ_ON);
        end
        bus_read(KD);
        tests++;
        if (irq !== IRQ_ON) begin
            failed++;
            $display("FAIL irq_hold: got %b want %b", irq, IRQ_ON);
        end
        tick();
        tests++;
        if (irq !== 1'b0) begin
            failed++;
            $display("FAIL irq_drop: got %b want 0", irq);
        end
    endtask

    task automatic test_rd_wr_conflict();
        logic [31:0] v;
        KEY = 4'b1111;
        repeat (8) tick();
        bus.addr  = KD;
        bus.wdata = 32'hF;
        bus.rd_en = 1'b1;
        bus.wr_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        peek(KC, v);
        tests++;
        if (v !== (IEB | 32'h1)) begin
            failed++;
            $display("FAIL rdwr_ready: got %h want %h", v, IEB | 32'h1);
        end
        peek(KD, v);
        tests++;
        if (v !== 32'h0) begin
            failed++;
            $display("FAIL rdwr_kdata: got %h want 0", v);
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        reset     = 1'b1;
        KEY       = 4'b1111;
        SW        = '0;
        bus.addr  = '0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_key_commit();
        test_glitch();
        test_overrun();
        test_commit_read();
        test_mid_reset();
        test_irq();
        test_rd_wr_conflict();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
